// File: rtl/uart_fifo_bridge.sv
// UART byte bridge between the CPU datapath handshake and the UART transceiver.
// One show-ahead FIFO per direction, stall-qualified CPU strobes, and a saturating RX overrun counter.

module uart_fifo_bridge_fifo #(
  parameter int DEPTH      = 8,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  push_req,
  input  logic [7:0]            push_data,
  input  logic                  pop_req,
  output logic [7:0]            head,
  output logic                  not_empty,
  output logic                  full,
  output logic [LOG2_DEPTH:0]   count
);

  localparam logic [LOG2_DEPTH:0] PTR_ZERO = {(LOG2_DEPTH+1){1'b0}};
  localparam logic [LOG2_DEPTH:0] PTR_ONE  = {{LOG2_DEPTH{1'b0}}, 1'b1};

  logic [7:0]          mem_r [DEPTH];
  logic [LOG2_DEPTH:0] wptr_r;
  logic [LOG2_DEPTH:0] rptr_r;
  logic                empty_s;
  logic                full_s;
  logic                push_s;
  logic                pop_s;

  assign empty_s = (wptr_r == rptr_r);
  assign full_s  = (wptr_r[LOG2_DEPTH] != rptr_r[LOG2_DEPTH]) &&
                   (wptr_r[LOG2_DEPTH-1:0] == rptr_r[LOG2_DEPTH-1:0]);

  // Full and empty come from registered pointers, so a push while full or a pop while empty is dropped.
  assign push_s = push_req && !full_s;
  assign pop_s  = pop_req && !empty_s;

  // Pointer update; both pointers wrap modulo 2*DEPTH.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wptr_r <= PTR_ZERO;
      rptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
    end
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wptr_r[LOG2_DEPTH-1:0]] <= push_data;
    end
  end

  // Show-ahead head byte, forced to zero while empty.
  always_comb begin
    head = 8'h00;
    if (!empty_s) begin
      head = mem_r[rptr_r[LOG2_DEPTH-1:0]];
    end else begin
      head = 8'h00;
    end
  end

  assign not_empty = !empty_s;
  assign full      = full_s;
  assign count     = wptr_r - rptr_r;

endmodule

module uart_fifo_bridge #(
  parameter int DEPTH      = 8,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                Stall,
  input  logic                DataOutReady,
  output logic [7:0]          DataOut,
  output logic                DataOutValid,
  input  logic                DataInValid,
  input  logic [7:0]          DataIn,
  output logic                DataInReady,
  input  logic [7:0]          uart_rx_data,
  input  logic                uart_rx_valid,
  output logic [7:0]          uart_tx_data,
  output logic                uart_tx_valid,
  input  logic                uart_tx_ready,
  output logic [LOG2_DEPTH:0] rx_count,
  output logic [LOG2_DEPTH:0] tx_count,
  output logic [7:0]          rx_overrun,
  input  logic                ovr_clear
);

  logic       rx_pop_req_s;
  logic       tx_push_req_s;
  logic       rx_full_s;
  logic       tx_full_s;
  logic       rx_drop_s;
  logic [7:0] rx_overrun_r;

  // CPU-side strobes only count on unstalled cycles, so a held strobe acts once per live cycle.
  assign rx_pop_req_s  = DataOutReady && !Stall;
  assign tx_push_req_s = DataInValid && !Stall;

  uart_fifo_bridge_fifo #(
    .DEPTH      (DEPTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_rx_fifo (
    .CLK       (CLK),
    .reset     (reset),
    .push_req  (uart_rx_valid),
    .push_data (uart_rx_data),
    .pop_req   (rx_pop_req_s),
    .head      (DataOut),
    .not_empty (DataOutValid),
    .full      (rx_full_s),
    .count     (rx_count)
  );

  uart_fifo_bridge_fifo #(
    .DEPTH      (DEPTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_tx_fifo (
    .CLK       (CLK),
    .reset     (reset),
    .push_req  (tx_push_req_s),
    .push_data (DataIn),
    .pop_req   (uart_tx_ready),
    .head      (uart_tx_data),
    .not_empty (uart_tx_valid),
    .full      (tx_full_s),
    .count     (tx_count)
  );

  assign DataInReady = !tx_full_s;
  assign rx_drop_s   = uart_rx_valid && rx_full_s;

  // Overrun counter: clear wins over a same-cycle drop, and the count sticks at 8'hFF.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_overrun_r <= 8'h00;
    end else if (ovr_clear) begin
      rx_overrun_r <= 8'h00;
    end else if (rx_drop_s && (rx_overrun_r != 8'hFF)) begin
      rx_overrun_r <= rx_overrun_r + 8'h01;
    end else begin
      rx_overrun_r <= rx_overrun_r;
    end
  end

  assign rx_overrun = rx_overrun_r;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: queue scoreboards per direction plus an overrun model.

module tb_uart_fifo_bridge;

  localparam int DEPTH      = 8;
  localparam int LOG2_DEPTH = 3;

  logic                CLK = 1'b0;
  logic                reset;
  logic                Stall;
  logic                DataOutReady;
  logic [7:0]          DataOut;
  logic                DataOutValid;
  logic                DataInValid;
  logic [7:0]          DataIn;
  logic                DataInReady;
  logic [7:0]          uart_rx_data;
  logic                uart_rx_valid;
  logic [7:0]          uart_tx_data;
  logic                uart_tx_valid;
  logic                uart_tx_ready;
  logic [LOG2_DEPTH:0] rx_count;
  logic [LOG2_DEPTH:0] tx_count;
  logic [7:0]          rx_overrun;
  logic                ovr_clear;

  uart_fifo_bridge #(.DEPTH(DEPTH), .LOG2_DEPTH(LOG2_DEPTH)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .Stall         (Stall),
    .DataOutReady  (DataOutReady),
    .DataOut       (DataOut),
    .DataOutValid  (DataOutValid),
    .DataInValid   (DataInValid),
    .DataIn        (DataIn),
    .DataInReady   (DataInReady),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .rx_count      (rx_count),
    .tx_count      (tx_count),
    .rx_overrun    (rx_overrun),
    .ovr_clear     (ovr_clear)
  );

  always #5 CLK = ~CLK;

  int         tests = 0;
  int         failed = 0;
  int         rcv = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] ovr_m = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One RX-side cycle: drive, update the model from pre-edge state, then check.
  task automatic rx_cycle(input logic v, input logic [7:0] d, input logic rd,
                          input logic st, input logic clr);
    logic       full_m;
    logic [7:0] h;
    full_m = (rx_q.size() == DEPTH);
    uart_rx_valid = v;
    uart_rx_data  = d;
    DataOutReady  = rd;
    Stall         = st;
    ovr_clear     = clr;
    if (rd && !st && rx_q.size() > 0) begin
      chk("rx_head", 32'(DataOut), 32'(rx_q[0]));
      h = rx_q.pop_front();
    end
    if (v && !full_m) rx_q.push_back(d);
    if (clr) ovr_m = 8'h00;
    else if (v && full_m && ovr_m != 8'hFF) ovr_m = ovr_m + 8'h01;
    tick();
    uart_rx_valid = 1'b0;
    DataOutReady  = 1'b0;
    Stall         = 1'b0;
    ovr_clear     = 1'b0;
    chk("rx_count", 32'(rx_count), 32'(rx_q.size()));
    chk("rx_valid", 32'(DataOutValid), 32'(rx_q.size() != 0));
    chk("rx_overrun", 32'(rx_overrun), 32'(ovr_m));
    if (rx_q.size() == 0) chk("rx_empty_head", 32'(DataOut), 32'h0);
  endtask

  // One TX-side cycle; acc reports whether the model accepted the push.
  task automatic tx_cycle(input logic v, input logic [7:0] d, input logic rdy,
                          input logic st, output logic acc);
    logic       full_m;
    logic [7:0] h;
    full_m = (tx_q.size() == DEPTH);
    DataInValid   = v;
    DataIn        = d;
    uart_tx_ready = rdy;
    Stall         = st;
    acc = 1'b0;
    if (rdy && tx_q.size() > 0) begin
      chk("tx_head", 32'(uart_tx_data), 32'(tx_q[0]));
      h = tx_q.pop_front();
      rcv++;
    end
    if (v && !st && !full_m) begin
      tx_q.push_back(d);
      acc = 1'b1;
    end
    tick();
    DataInValid   = 1'b0;
    uart_tx_ready = 1'b0;
    Stall         = 1'b0;
    chk("tx_count", 32'(tx_count), 32'(tx_q.size()));
    chk("tx_valid", 32'(uart_tx_valid), 32'(tx_q.size() != 0));
    chk("tx_ready", 32'(DataInReady), 32'(tx_q.size() != DEPTH));
    if (tx_q.size() == 0) chk("tx_empty_head", 32'(uart_tx_data), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   sent;
    reset = 1'b0; Stall = 1'b0; DataOutReady = 1'b0; DataInValid = 1'b0; DataIn = 8'h00;
    uart_rx_data = 8'h00; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0; ovr_clear = 1'b0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b1;
    tick();
    chk("rst_rx_count", 32'(rx_count), 32'h0);
    chk("rst_tx_ready", 32'(DataInReady), 32'h1);

    // Mid-stream reset with three RX bytes held.
    rx_cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    rx_cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    rx_cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    chk("async_rx_count", 32'(rx_count), 32'h0);
    chk("async_rx_valid", 32'(DataOutValid), 32'h0);
    @(posedge CLK);
    #1 reset = 1'b1;
    rx_q.delete();
    ovr_m = 8'h00;
    tick();
    chk("post_rst_rx_count", 32'(rx_count), 32'h0);
    chk("post_rst_rx_valid", 32'(DataOutValid), 32'h0);
    chk("post_rst_tx_ready", 32'(DataInReady), 32'h1);
    chk("post_rst_overrun", 32'(rx_overrun), 32'h0);
    chk("post_rst_dataout", 32'(DataOut), 32'h0);
    chk("post_rst_tx_valid", 32'(uart_tx_valid), 32'h0);
    chk("post_rst_tx_data", 32'(uart_tx_data), 32'h0);
    chk("post_rst_tx_count", 32'(tx_count), 32'h0);

    // Three bytes in, three unstalled pops out in order.
    rx_cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    rx_cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    rx_cycle(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    repeat (3) rx_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Overfill by two, clear priority, saturation, then clear.
    for (int i = 0; i < 10; i++) rx_cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    chk("fill_rx_count", 32'(rx_count), 32'h8);
    chk("fill_overrun", 32'(rx_overrun), 32'h2);
    chk("fill_head", 32'(DataOut), 32'h50);
    rx_cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("clr_priority", 32'(rx_overrun), 32'h0);
    for (int i = 0; i < 260; i++) rx_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("ovr_saturate", 32'(rx_overrun), 32'hFF);
    rx_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Push and pop together while full: pop wins, push dropped.
    rx_cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("full_simul_count", 32'(rx_count), 32'h7);
    rx_cycle(1'b1, 8'h78, 1'b1, 1'b0, 1'b0);
    repeat (2) rx_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // DataOutReady held four cycles with stall in cycles 2-3.
    chk("pre_stall_count", 32'(rx_count), 32'h5);
    rx_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    rx_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    rx_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    rx_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("stall_count", 32'(rx_count), 32'h3);
    repeat (3) rx_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    rx_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    rx_cycle(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
    chk("empty_simul_count", 32'(rx_count), 32'h1);
    rx_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // TX fill, ignored ninth push, full push+pop, drain.
    for (int i = 0; i < 8; i++) tx_cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, acc);
    chk("tx_full_ready", 32'(DataInReady), 32'h0);
    tx_cycle(1'b1, 8'hAF, 1'b0, 1'b0, acc);
    chk("tx_ninth_count", 32'(tx_count), 32'h8);
    tx_cycle(1'b1, 8'hB0, 1'b1, 1'b0, acc);
    chk("tx_simul_count", 32'(tx_count), 32'h7);
    tx_cycle(1'b1, 8'hB1, 1'b1, 1'b0, acc);
    for (int i = 0; i < 20 && tx_q.size() > 0; i++) tx_cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("tx_drained", 32'(tx_count), 32'h0);
    tx_cycle(1'b1, 8'hC0, 1'b0, 1'b1, acc);
    tx_cycle(1'b1, 8'hC1, 1'b1, 1'b0, acc);
    chk("tx_empty_simul", 32'(tx_count), 32'h1);
    tx_cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Wrap: 20 bytes through TX with random transmitter readiness.
    rcv = 0;
    sent = 0;
    for (int cyc = 0; cyc < 400 && (sent < 20 || tx_q.size() > 0); cyc++) begin
      tx_cycle(sent < 20, 8'(8'h10 + sent), $urandom_range(0, 1) == 1, 1'b0, acc);
      if (acc) sent++;
    end
    chk("wrap_sent", 32'(sent), 32'd20);
    chk("wrap_rcv", 32'(rcv), 32'd20);
    chk("wrap_count", 32'(tx_count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
